// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive-side sequence checker.
package uart_pkg;

  localparam int UART_DATA_WIDTH = 8;
  localparam int UART_CNT_WIDTH  = 16;

  typedef enum logic [1:0] {
    S_HUNT   = 2'd0,
    S_LOCK   = 2'd1,
    S_RESYNC = 2'd2
  } seq_state_e;

  localparam logic ERR_TYPE_MISMATCH = 1'b0;
  localparam logic ERR_TYPE_PARITY   = 1'b1;

endpackage

// File: rtl/uart_seq_checker_sat_counter.sv
// Saturating up-counter with synchronous reset/clear; sticks at all-ones.
module sat_counter #(
  parameter int P_WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               inc,
  output logic [P_WIDTH-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + P_WIDTH'(1);
    end
  end

endmodule

// File: rtl/uart_seq_checker.sv
// Incrementing-byte stream checker for the uart_rx output: lock, resync, timeout, stats.
// Optional first-error capture ports are built when UART_SEQ_CHK_FIRST_ERR_EN is defined.
//
//   state    | meaning
//   ---------+---------------------------------------------------------------
//   S_HUNT   | no reference yet; first parity-good byte seeds the expectation
//   S_LOCK   | stream in sequence; o_locked high
//   S_RESYNC | after a mismatch; needs P_RESYNC_CNT good bytes in a row to relock
module uart_seq_checker
  import uart_pkg::*;
#(
  parameter int P_UART_DATA_WIDTH = UART_DATA_WIDTH,
  parameter int P_CNT_WIDTH       = UART_CNT_WIDTH,
  parameter int P_RESYNC_CNT      = 4,
  parameter int P_TIMEOUT_CYCLES  = 100000
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_clr,
  input  logic                         i_rx_valid,
  input  logic [P_UART_DATA_WIDTH-1:0] i_rx_data,
  input  logic                         i_rx_check_ok,
  output logic                         o_locked,
  output logic                         o_err,
  output logic                         o_timeout,
  output logic [P_CNT_WIDTH-1:0]       o_good_cnt,
  output logic [P_CNT_WIDTH-1:0]       o_mismatch_cnt,
  output logic [P_CNT_WIDTH-1:0]       o_parity_cnt
`ifdef UART_SEQ_CHK_FIRST_ERR_EN
  ,
  output logic                         o_first_err_valid,
  output logic [P_UART_DATA_WIDTH-1:0] o_first_err_exp,
  output logic [P_UART_DATA_WIDTH-1:0] o_first_err_got,
  output logic                         o_first_err_type
`endif
);

  localparam int  TO_W   = (P_TIMEOUT_CYCLES > 1) ? $clog2(P_TIMEOUT_CYCLES) : 1;
  localparam bit  TO_EN  = (P_TIMEOUT_CYCLES > 0);
  localparam logic [TO_W-1:0] TO_LOAD =
    TO_W'((P_TIMEOUT_CYCLES > 0) ? (P_TIMEOUT_CYCLES - 1) : 0);
  localparam int  RUN_W  = $clog2(P_RESYNC_CNT + 1);
  localparam logic [RUN_W-1:0] RUN_TARGET = RUN_W'(P_RESYNC_CNT);

  seq_state_e                   state_q, state_d;
  logic [P_UART_DATA_WIDTH-1:0] expect_q, expect_d;
  logic [RUN_W-1:0]             run_q, run_d;
  logic [TO_W-1:0]              idle_q, idle_d;
  logic                         err_d;
  logic                         to_d;
  logic                         inc_good, inc_mis, inc_par;
  logic                         hold;
  logic                         match;
  logic                         timeout_hit;
  logic [P_UART_DATA_WIDTH-1:0] data_inc, expect_inc;

  assign hold        = i_rst | i_clr;
  assign match       = (i_rx_data == expect_q);
  assign data_inc    = i_rx_data + P_UART_DATA_WIDTH'(1);
  assign expect_inc  = expect_q + P_UART_DATA_WIDTH'(1);
  // Idle timer counts down from TO_LOAD; reaching zero with no beat is the timeout.
  assign timeout_hit = TO_EN && (idle_q == '0);

  always_comb begin
    state_d  = state_q;
    expect_d = expect_q;
    run_d    = run_q;
    idle_d   = idle_q;
    err_d    = 1'b0;
    to_d     = 1'b0;
    inc_good = 1'b0;
    inc_mis  = 1'b0;
    inc_par  = 1'b0;

    if ((state_q == S_HUNT) || i_rx_valid) begin
      idle_d = TO_LOAD;
    end else if (idle_q != '0) begin
      idle_d = idle_q - TO_W'(1);
    end

    case (state_q)
      S_HUNT: begin
        if (i_rx_valid) begin
          if (i_rx_check_ok) begin
            expect_d = data_inc;
            inc_good = 1'b1;
            state_d  = S_LOCK;
          end else begin
            inc_par = 1'b1;
            err_d   = 1'b1;
          end
        end
      end

      S_LOCK: begin
        if (i_rx_valid) begin
          if (!i_rx_check_ok) begin
            inc_par  = 1'b1;
            err_d    = 1'b1;
            expect_d = expect_inc;
          end else if (match) begin
            inc_good = 1'b1;
            expect_d = expect_inc;
          end else begin
            inc_mis  = 1'b1;
            err_d    = 1'b1;
            expect_d = data_inc;
            run_d    = '0;
            state_d  = S_RESYNC;
          end
        end else if (timeout_hit) begin
          to_d    = 1'b1;
          state_d = S_HUNT;
        end
      end

      S_RESYNC: begin
        if (i_rx_valid) begin
          if (!i_rx_check_ok) begin
            inc_par  = 1'b1;
            err_d    = 1'b1;
            expect_d = expect_inc;
            run_d    = '0;
          end else if (match) begin
            inc_good = 1'b1;
            expect_d = expect_inc;
            if ((run_q + RUN_W'(1)) == RUN_TARGET) begin
              run_d   = '0;
              state_d = S_LOCK;
            end else begin
              run_d = run_q + RUN_W'(1);
            end
          end else begin
            inc_mis  = 1'b1;
            err_d    = 1'b1;
            expect_d = data_inc;
            run_d    = '0;
          end
        end else if (timeout_hit) begin
          to_d    = 1'b1;
          state_d = S_HUNT;
        end
      end

      default: begin
        state_d = S_HUNT;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (hold) begin
      state_q   <= S_HUNT;
      expect_q  <= '0;
      run_q     <= '0;
      idle_q    <= TO_LOAD;
      o_locked  <= 1'b0;
      o_err     <= 1'b0;
      o_timeout <= 1'b0;
    end else begin
      state_q   <= state_d;
      expect_q  <= expect_d;
      run_q     <= run_d;
      idle_q    <= idle_d;
      o_locked  <= (state_d == S_LOCK);
      o_err     <= err_d;
      o_timeout <= to_d;
    end
  end

  sat_counter #(.P_WIDTH(P_CNT_WIDTH)) u_good_cnt (
    .clk (i_clk),
    .rst (i_rst),
    .clr (i_clr),
    .inc (inc_good),
    .cnt (o_good_cnt)
  );

  sat_counter #(.P_WIDTH(P_CNT_WIDTH)) u_mismatch_cnt (
    .clk (i_clk),
    .rst (i_rst),
    .clr (i_clr),
    .inc (inc_mis),
    .cnt (o_mismatch_cnt)
  );

  sat_counter #(.P_WIDTH(P_CNT_WIDTH)) u_parity_cnt (
    .clk (i_clk),
    .rst (i_rst),
    .clr (i_clr),
    .inc (inc_par),
    .cnt (o_parity_cnt)
  );

`ifdef UART_SEQ_CHK_FIRST_ERR_EN
  // Sticky snapshot of the first error since reset/clear.
  always_ff @(posedge i_clk) begin
    if (hold) begin
      o_first_err_valid <= 1'b0;
      o_first_err_exp   <= '0;
      o_first_err_got   <= '0;
      o_first_err_type  <= ERR_TYPE_MISMATCH;
    end else if (err_d && !o_first_err_valid) begin
      o_first_err_valid <= 1'b1;
      o_first_err_exp   <= expect_q;
      o_first_err_got   <= i_rx_data;
      o_first_err_type  <= inc_par ? ERR_TYPE_PARITY : ERR_TYPE_MISMATCH;
    end
  end
`endif

endmodule
